alu_issue_decode: RTL and testbench
===================================

// Module: alu_issue_decode
// PURPOSE
//  Decode/issue stage feeding the ALU. Accepts 32-bit RV64I instructions from fetch (valid/ready),
//  reads rs1/rs2 from the register file, and registers op1/op2/funct3/funct7/imm for the ALU.
//  Tracks a 31-entry busy scoreboard and stalls RAW hazards until writeback clears the bit.
//  Handles OP, OP-IMM, LUI and AUIPC; every other opcode issues flagged illegal.
// PARAMETERS
//  XLEN        64   datapath width; op1/op2/pc width
//  REG_ADDR_W  5    register index width
// PORTS
//  CLK          in   1     clock; all state updates on posedge
//  RST          in   1     asynchronous, active-high reset
//  if_valid     in   1     fetch offers an instruction
//  if_ready     out  1     stage accepts if_inst this cycle
//  if_inst      in   32    instruction word
//  if_pc        in   XLEN  instruction address
//  rf_rs1_addr  out  5     inst[19:15], combinational
//  rf_rs2_addr  out  5     inst[24:20], combinational
//  rf_rs1_data  in   XLEN  same-cycle read data
//  rf_rs2_data  in   XLEN  same-cycle read data
//  ex_valid     out  1     output register holds an instruction
//  ex_ready     in   1     ALU consumes it
//  ex_op1/op2   out  XLEN  ALU operands
//  ex_funct3    out  3     ALU funct3
//  ex_funct7    out  7     ALU funct7
//  ex_imm       out  1     op2 is an immediate
//  ex_word      out  1     32-bit W-form op (see CONFIGURATION)
//  ex_rd        out  5     destination index
//  ex_rd_we     out  1     write back rd
//  ex_illegal   out  1     unsupported opcode
//  wb_valid     in   1     writeback occurred
//  wb_rd        in   5     written register; clears busy bit
//  flush        in   1     discard held and incoming instruction
// BEHAVIOUR
//  Reset: all ex_* outputs 0, scoreboard cleared; if_ready follows the equation below.
//  Handshake: a transfer on a side occurs when valid & ready are high at the same posedge.
//   The output register is one entry with latency 1: accept at edge N gives ex_valid at N+1.
//   ex_* stays stable while ex_valid & !ex_ready.
//  if_ready = (!ex_valid | ex_ready) & !hazard & !flush.
//   hazard = (uses_rs1 & busy[rs1]) | (uses_rs2 & busy[rs2]); x0 is never busy.
//  Decode:
//   OP (0110011): op1=rs1, op2=rs2, funct3/funct7 from inst, imm=0.
//   OP-IMM (0010011): op1=rs1, op2=sext(inst[31:20]), imm=1.
//    Shifts (funct3 001/101): funct7={inst[31:26],1'b0}; otherwise funct7=0.
//   LUI: op1=0, op2=sext({inst[31:12],12'b0}), funct3=000, imm=1.
//   AUIPC: op1=pc, op2 as for LUI.
//   Other opcode: ex_illegal=1, rd_we=0, operands 0.
//   rd_we=1 for every legal op; busy is set only when rd!=0.
//  Scoreboard busy[31:1] is registered; an accepted instruction with rd_we & rd!=0 sets busy[rd].
//   wb_valid clears busy[wb_rd]; there is no bypass, so a stalled consumer issues the cycle after the clear.
//   Set and clear of the same index in the same cycle: set wins.
//  Flush: ex_valid<=0 next edge; busy[ex_rd] of the discarded held instruction is cleared
//   (if it set one); no accept that cycle. Bits of instructions already consumed by EX persist.
//  Reset mid-stall or mid-backpressure: everything returns to reset values immediately.
// CONFIGURATION
//  DECODE_RV64W_EN defined: OP-IMM-32 (0011011) and OP-32 (0111011) decode like OP-IMM/OP with ex_word=1.
//   Shift funct7 = inst[31:25] for these opcodes.
//  Undefined: those opcodes are illegal and ex_word is tied 0.
// STRUCTURE
//  Shared package rv_isa_pkg: opcode localparams (OP, OP_IMM, LUI, AUIPC, OP_32, OP_IMM_32),
//   funct3 codes (ADD_SUB, SLL, SLT, SLTU, XOR, SRL_SRA, OR, AND), FUNCT7_ALT=7'b0100000.
//  Sub-module decode_scoreboard: busy vector, set/clear ports, two hazard lookups.
// TESTING
//  1 ADDI x1,x0,5 (0x00500093), ex_ready=1 -> next cycle ex_valid=1, op1=0, op2=5, funct3=000,
//    imm=1, rd=1, rd_we=1; busy[1]=1.
//  2 SRAI x2,x1,3 (0x4030D113), x1 not busy -> funct3=101, funct7=0100000, op2[5:0]=3, imm=1.
//  3 ADDI x1 then ADD x3,x1,x1 (0x001081B3) -> if_ready=0 until wb_valid with wb_rd=1;
//    ADD is accepted the following cycle with op1=op2=rf data.
//  4 ex_ready=0 for 3 cycles while ex_valid=1 -> outputs unchanged, if_ready=0; resumes when ex_ready=1.
//  5 Opcode 0x0000007F -> ex_illegal=1, rd_we=0, no busy bit set; OP-32 is illegal unless DECODE_RV64W_EN.
//  6 RST pulse during a RAW stall -> ex_valid=0, busy all 0 in the same cycle; next ADD issues without stall.

Source files
------------

// File: rtl/rv_isa_pkg.sv
// RV64I encodings and decode helpers shared by the issue/decode stage.
// OP_32/OP_IMM_32 decode only when DECODE_RV64W_EN is defined in the top.
package rv_isa_pkg;

    localparam logic [6:0] OP        = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] LUI       = 7'b0110111;
    localparam logic [6:0] AUIPC     = 7'b0010111;
    localparam logic [6:0] OP_32     = 7'b0111011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;

    localparam logic [2:0] ADD_SUB = 3'b000;
    localparam logic [2:0] SLL     = 3'b001;
    localparam logic [2:0] SLT     = 3'b010;
    localparam logic [2:0] SLTU    = 3'b011;
    localparam logic [2:0] XOR     = 3'b100;
    localparam logic [2:0] SRL_SRA = 3'b101;
    localparam logic [2:0] OR      = 3'b110;
    localparam logic [2:0] AND     = 3'b111;

    localparam logic [6:0] FUNCT7_ALT = 7'b0100000;

    typedef enum logic [2:0] {
        CLS_ILLEGAL,
        CLS_REG,
        CLS_IMM,
        CLS_LUI,
        CLS_AUIPC
    } op_class_e;

    function automatic logic is_shift(input logic [2:0] funct3);
        return (funct3 == SLL) || (funct3 == SRL_SRA);
    endfunction

endpackage

// File: rtl/alu_issue_decode_if.sv
// Fetch, register-file, ALU and writeback signals of the decode/issue stage.
// slave is the stage itself; master is the surrounding pipeline.
interface alu_issue_decode_if #(
    parameter int XLEN       = 64,
    parameter int REG_ADDR_W = 5
);
    logic                  if_valid;
    logic                  if_ready;
    logic [31:0]           if_inst;
    logic [XLEN-1:0]       if_pc;

    logic [REG_ADDR_W-1:0] rf_rs1_addr;
    logic [REG_ADDR_W-1:0] rf_rs2_addr;
    logic [XLEN-1:0]       rf_rs1_data;
    logic [XLEN-1:0]       rf_rs2_data;

    logic                  ex_valid;
    logic                  ex_ready;
    logic [XLEN-1:0]       ex_op1;
    logic [XLEN-1:0]       ex_op2;
    logic [2:0]            ex_funct3;
    logic [6:0]            ex_funct7;
    logic                  ex_imm;
    logic                  ex_word;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_rd_we;
    logic                  ex_illegal;

    logic                  wb_valid;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic                  flush;

    modport slave (
        input  if_valid, if_inst, if_pc,
        output if_ready,
        output rf_rs1_addr, rf_rs2_addr,
        input  rf_rs1_data, rf_rs2_data,
        output ex_valid, ex_op1, ex_op2, ex_funct3, ex_funct7,
        output ex_imm, ex_word, ex_rd, ex_rd_we, ex_illegal,
        input  ex_ready,
        input  wb_valid, wb_rd, flush
    );

    modport master (
        output if_valid, if_inst, if_pc,
        input  if_ready,
        input  rf_rs1_addr, rf_rs2_addr,
        output rf_rs1_data, rf_rs2_data,
        input  ex_valid, ex_op1, ex_op2, ex_funct3, ex_funct7,
        input  ex_imm, ex_word, ex_rd, ex_rd_we, ex_illegal,
        output ex_ready,
        output wb_valid, wb_rd, flush
    );
endinterface

// File: rtl/alu_issue_decode_scoreboard.sv
// Register busy scoreboard: one bit per architectural register, x0 never busy.
// Set beats either clear when they hit the same index in one cycle.
module decode_scoreboard
    import rv_isa_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_idx,
    input  logic                  wb_clr_en,
    input  logic [REG_ADDR_W-1:0] wb_clr_idx,
    input  logic                  flush_clr_en,
    input  logic [REG_ADDR_W-1:0] flush_clr_idx,
    input  logic [REG_ADDR_W-1:0] rs1_idx,
    input  logic [REG_ADDR_W-1:0] rs2_idx,
    output logic                  rs1_busy,
    output logic                  rs2_busy
);
    localparam int unsigned NREG = 2 ** REG_ADDR_W;

    logic [NREG-1:1] busy_q;
    logic [NREG-1:1] busy_d;
    logic [NREG-1:0] busy_full;

    always_comb begin
        busy_d = busy_q;
        for (int unsigned i = 1; i < NREG; i++) begin
            if (wb_clr_en && (wb_clr_idx == REG_ADDR_W'(i))) begin
                busy_d[i] = 1'b0;
            end
            if (flush_clr_en && (flush_clr_idx == REG_ADDR_W'(i))) begin
                busy_d[i] = 1'b0;
            end
            if (set_en && (set_idx == REG_ADDR_W'(i))) begin
                busy_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Bit 0 is a constant zero so x0 lookups need no special case.
    assign busy_full = {busy_q, 1'b0};
    assign rs1_busy  = busy_full[rs1_idx];
    assign rs2_busy  = busy_full[rs2_idx];

endmodule

// File: rtl/alu_issue_decode.sv
// Decode/issue stage: decodes RV64I OP/OP-IMM/LUI/AUIPC, stalls RAW hazards, registers ALU inputs.
// Define DECODE_RV64W_EN to also decode OP-32/OP-IMM-32 as W-form ops (ex_word=1).
module alu_issue_decode
    import rv_isa_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int REG_ADDR_W = 5
) (
    input  logic              CLK,
    input  logic              RST,
    alu_issue_decode_if.slave bus
);
    logic [31:0]           inst;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic [2:0]            funct3;

    op_class_e cls;
    logic      word_op;
    logic      uses_rs1;
    logic      uses_rs2;
    logic      rs1_busy;
    logic      rs2_busy;
    logic      hazard;
    logic      ready;
    logic      accept;

    logic [XLEN-1:0] d_op1;
    logic [XLEN-1:0] d_op2;
    logic [2:0]      d_funct3;
    logic [6:0]      d_funct7;
    logic            d_imm;
    logic            d_word;
    logic            d_rd_we;
    logic            d_illegal;

    logic                  ex_valid_q;
    logic [XLEN-1:0]       ex_op1_q;
    logic [XLEN-1:0]       ex_op2_q;
    logic [2:0]            ex_funct3_q;
    logic [6:0]            ex_funct7_q;
    logic                  ex_imm_q;
    logic                  ex_word_q;
    logic [REG_ADDR_W-1:0] ex_rd_q;
    logic                  ex_rd_we_q;
    logic                  ex_illegal_q;

    assign inst   = bus.if_inst;
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign rd     = inst[11:7];
    assign funct3 = inst[14:12];

    assign bus.rf_rs1_addr = rs1;
    assign bus.rf_rs2_addr = rs2;

    always_comb begin
        cls     = CLS_ILLEGAL;
        word_op = 1'b0;
        case (inst[6:0])
            OP:        cls = CLS_REG;
            OP_IMM:    cls = CLS_IMM;
            LUI:       cls = CLS_LUI;
            AUIPC:     cls = CLS_AUIPC;
`ifdef DECODE_RV64W_EN
            OP_32: begin
                cls     = CLS_REG;
                word_op = 1'b1;
            end
            OP_IMM_32: begin
                cls     = CLS_IMM;
                word_op = 1'b1;
            end
`endif
            default:   cls = CLS_ILLEGAL;
        endcase
    end

    assign uses_rs1 = (cls == CLS_REG) || (cls == CLS_IMM);
    assign uses_rs2 = (cls == CLS_REG);
    assign hazard   = (uses_rs1 && rs1_busy) || (uses_rs2 && rs2_busy);
    assign ready    = (!ex_valid_q || bus.ex_ready) && !hazard && !bus.flush;
    assign accept   = bus.if_valid && ready;

    assign bus.if_ready = ready;

    always_comb begin
        d_op1     = '0;
        d_op2     = '0;
        d_funct3  = '0;
        d_funct7  = '0;
        d_imm     = 1'b0;
        d_word    = 1'b0;
        d_rd_we   = 1'b0;
        d_illegal = 1'b0;
        case (cls)
            CLS_REG: begin
                d_op1    = bus.rf_rs1_data;
                d_op2    = bus.rf_rs2_data;
                d_funct3 = funct3;
                d_funct7 = inst[31:25];
                d_word   = word_op;
                d_rd_we  = 1'b1;
            end
            CLS_IMM: begin
                d_op1    = bus.rf_rs1_data;
                d_op2    = {{(XLEN-12){inst[31]}}, inst[31:20]};
                d_funct3 = funct3;
                // RV64 shifts use a 6-bit shamt, so inst[25] belongs to the amount, not funct7.
                if (is_shift(funct3)) begin
                    d_funct7 = word_op ? inst[31:25] : {inst[31:26], 1'b0};
                end
                d_imm    = 1'b1;
                d_word   = word_op;
                d_rd_we  = 1'b1;
            end
            CLS_LUI, CLS_AUIPC: begin
                d_op1   = (cls == CLS_AUIPC) ? bus.if_pc : '0;
                d_op2   = {{(XLEN-32){inst[31]}}, inst[31:12], 12'b0};
                d_imm   = 1'b1;
                d_rd_we = 1'b1;
            end
            default: begin
                d_illegal = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ex_valid_q   <= 1'b0;
            ex_op1_q     <= '0;
            ex_op2_q     <= '0;
            ex_funct3_q  <= '0;
            ex_funct7_q  <= '0;
            ex_imm_q     <= 1'b0;
            ex_word_q    <= 1'b0;
            ex_rd_q      <= '0;
            ex_rd_we_q   <= 1'b0;
            ex_illegal_q <= 1'b0;
        end else if (accept) begin
            ex_valid_q   <= 1'b1;
            ex_op1_q     <= d_op1;
            ex_op2_q     <= d_op2;
            ex_funct3_q  <= d_funct3;
            ex_funct7_q  <= d_funct7;
            ex_imm_q     <= d_imm;
            ex_word_q    <= d_word;
            ex_rd_q      <= rd;
            ex_rd_we_q   <= d_rd_we;
            ex_illegal_q <= d_illegal;
        end else if (bus.flush || bus.ex_ready) begin
            ex_valid_q   <= 1'b0;
        end
    end

    assign bus.ex_valid   = ex_valid_q;
    assign bus.ex_op1     = ex_op1_q;
    assign bus.ex_op2     = ex_op2_q;
    assign bus.ex_funct3  = ex_funct3_q;
    assign bus.ex_funct7  = ex_funct7_q;
    assign bus.ex_imm     = ex_imm_q;
    assign bus.ex_word    = ex_word_q;
    assign bus.ex_rd      = ex_rd_q;
    assign bus.ex_rd_we   = ex_rd_we_q;
    assign bus.ex_illegal = ex_illegal_q;

    // A flushed entry only releases its bit if EX did not take it on this same edge.
    decode_scoreboard #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_scoreboard (
        .CLK           (CLK),
        .RST           (RST),
        .set_en        (accept && d_rd_we && (rd != '0)),
        .set_idx       (rd),
        .wb_clr_en     (bus.wb_valid),
        .wb_clr_idx    (bus.wb_rd),
        .flush_clr_en  (bus.flush && ex_valid_q && !bus.ex_ready && ex_rd_we_q),
        .flush_clr_idx (ex_rd_q),
        .rs1_idx       (rs1),
        .rs2_idx       (rs2),
        .rs1_busy      (rs1_busy),
        .rs2_busy      (rs2_busy)
    );

endmodule

// File: tb/tb_alu_issue_decode.sv
// Scoreboard bench for alu_issue_decode: expected ALU bundles are queued on accept, compared on consume.
// Expectations follow DECODE_RV64W_EN the same way the design does.
module tb_alu_issue_decode;

    typedef struct packed {
        logic [63:0] op1;
        logic [63:0] op2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        imm;
        logic        word;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    logic [31:0] busy_obs;

    alu_issue_decode_if #(.XLEN(64), .REG_ADDR_W(5)) bus ();

    alu_issue_decode #(.XLEN(64), .REG_ADDR_W(5)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] rf_val(input logic [4:0] a);
        return (a == 5'd0) ? 64'd0 : {27'h5A5A5A5, a, 27'h0, a};
    endfunction

    assign bus.rf_rs1_data = rf_val(bus.rf_rs1_addr);
    assign bus.rf_rs2_data = rf_val(bus.rf_rs2_addr);
    assign busy_obs        = {dut.u_scoreboard.busy_q, 1'b0};

    function automatic exp_t model(input logic [31:0] i, input logic [63:0] pc);
        exp_t e;
        e    = '0;
        e.rd = i[11:7];
        case (i[6:0])
            7'h33, 7'h3B: begin
                e.op1 = rf_val(i[19:15]);
                e.op2 = rf_val(i[24:20]);
                e.f3  = i[14:12];
                e.f7  = i[31:25];
                e.we  = 1'b1;
                e.word = (i[6:0] == 7'h3B);
            end
            7'h13, 7'h1B: begin
                e.op1 = rf_val(i[19:15]);
                e.op2 = {{52{i[31]}}, i[31:20]};
                e.f3  = i[14:12];
                e.imm = 1'b1;
                e.we  = 1'b1;
                e.word = (i[6:0] == 7'h1B);
                if (i[13:12] == 2'b01) e.f7 = e.word ? i[31:25] : {i[31:26], 1'b0};
            end
            7'h37, 7'h17: begin
                e.op1 = (i[6:0] == 7'h17) ? pc : 64'd0;
                e.op2 = {{32{i[31]}}, i[31:12], 12'h000};
                e.imm = 1'b1;
                e.we  = 1'b1;
            end
            default: e.ill = 1'b1;
        endcase
`ifndef DECODE_RV64W_EN
        if (i[6:0] == 7'h3B || i[6:0] == 7'h1B) begin
            e     = '0;
            e.rd  = i[11:7];
            e.ill = 1'b1;
        end
`endif
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Consume side compares against the queue head; accept side pushes the model result.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (bus.ex_valid && bus.ex_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ex", 64'd1, 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("ex_op1", bus.ex_op1, mon_e.op1);
                    check("ex_op2", bus.ex_op2, mon_e.op2);
                    check("ex_ctrl",
                          64'({bus.ex_funct3, bus.ex_funct7, bus.ex_imm, bus.ex_word,
                               bus.ex_rd, bus.ex_rd_we, bus.ex_illegal}),
                          64'({mon_e.f3, mon_e.f7, mon_e.imm, mon_e.word,
                               mon_e.rd, mon_e.we, mon_e.ill}));
                end
            end else if (bus.flush && bus.ex_valid && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
            end
            if (bus.if_valid && bus.if_ready) exp_q.push_back(model(bus.if_inst, bus.if_pc));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] inst, input logic [63:0] pc);
        logic done;
        done         = 1'b0;
        bus.if_valid = 1'b1;
        bus.if_inst  = inst;
        bus.if_pc    = pc;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            done = bus.if_ready;
            tick();
        end
        bus.if_valid = 1'b0;
        if (!done) check("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic wb_clear(input logic [4:0] r);
        bus.wb_valid = 1'b1;
        bus.wb_rd    = r;
        tick();
        bus.wb_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ri;
        bus.if_valid = 1'b0;
        bus.if_inst  = 32'h0;
        bus.if_pc    = 64'h0;
        bus.ex_ready = 1'b1;
        bus.wb_valid = 1'b0;
        bus.wb_rd    = 5'd0;
        bus.flush    = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_ex_valid", 64'(bus.ex_valid), 64'd0);
        check("rst_ex_bus", 64'({bus.ex_op1[15:0], bus.ex_op2[15:0], bus.ex_funct3, bus.ex_funct7,
                                 bus.ex_imm, bus.ex_word, bus.ex_rd, bus.ex_rd_we, bus.ex_illegal}), 64'd0);
        check("rst_if_ready", 64'(bus.if_ready), 64'd1);
        check("rst_busy", 64'(busy_obs), 64'd0);
        tick();

        // ADDI x1,x0,5: one-cycle latency, sets busy[1]
        send(32'h00500093, 64'h100);
        check("addi_latency", 64'(bus.ex_valid), 64'd1);
        check("addi_busy", 64'(busy_obs), 64'h2);
        wb_clear(5'd1);

        // SRAI x2,x1,3
        send(32'h4030D113, 64'h104);
        check("srai_busy", 64'(busy_obs), 64'h4);
        wb_clear(5'd2);

        // RAW: ADDI x1 then ADD x3,x1,x1 stalls until writeback of x1
        send(32'h00500093, 64'h108);
        bus.if_valid = 1'b1;
        bus.if_inst  = 32'h001081B3;
        bus.if_pc    = 64'h10C;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("raw_stall", 64'(bus.if_ready), 64'd0);
            tick();
        end
        check("rs1_addr", 64'(bus.rf_rs1_addr), 64'd1);
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 5'd1;
        @(negedge clk);
        check("raw_wb_cycle", 64'(bus.if_ready), 64'd0);
        tick();
        bus.wb_valid = 1'b0;
        @(negedge clk);
        check("raw_release", 64'(bus.if_ready), 64'd1);
        tick();
        bus.if_valid = 1'b0;
        wb_clear(5'd3);

        // Backpressure: ADDI x5,x0,7 held three cycles, ADDI x6,x0,9 waits
        bus.ex_ready = 1'b0;
        send(32'h00700293, 64'h110);
        bus.if_valid = 1'b1;
        bus.if_inst  = 32'h00900313;
        bus.if_pc    = 64'h114;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_valid", 64'(bus.ex_valid), 64'd1);
            check("bp_op2", bus.ex_op2, 64'd7);
            check("bp_if_ready", 64'(bus.if_ready), 64'd0);
            tick();
        end
        bus.ex_ready = 1'b1;
        @(negedge clk);
        check("bp_resume", 64'(bus.if_ready), 64'd1);
        tick();
        bus.if_valid = 1'b0;

        // Set and clear of x5 in the same cycle: set wins
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 5'd5;
        send(32'h00700293, 64'h118);
        bus.wb_valid = 1'b0;
        check("set_wins", 64'(busy_obs), 64'h60);
        wb_clear(5'd5);
        wb_clear(5'd6);
        check("busy_cleared", 64'(busy_obs), 64'd0);

        // Illegal opcode, OP-32, LUI, AUIPC, SUB, ADD to x0
        send(32'h0000007F, 64'h11C);
        check("illegal_busy", 64'(busy_obs), 64'd0);
        send(32'h002083BB, 64'h120);
`ifdef DECODE_RV64W_EN
        check("op32_busy", 64'(busy_obs), 64'h80);
        wb_clear(5'd7);
`else
        check("op32_busy", 64'(busy_obs), 64'd0);
`endif
        send(32'h80000437, 64'h124);
        send(32'h12345497, 64'h1000);
        send(32'h40208533, 64'h128);
        send(32'h00208033, 64'h12C);
        wb_clear(5'd8);
        wb_clear(5'd9);
        wb_clear(5'd10);
        check("x0_never_busy", 64'(busy_obs), 64'd0);

        // Random OP / OP-IMM
        for (int k = 0; k < 8; k++) begin
            ri = $urandom;
            ri[6:0]  = ($urandom_range(0, 1) == 0) ? 7'h33 : 7'h13;
            ri[11:7] = 5'($urandom_range(1, 31));
            if (ri[6:0] == 7'h33) ri[31:25] = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20;
            send(ri, 64'($urandom));
            wb_clear(ri[11:7]);
        end

        // Flush of a held ADDI x4 releases busy[4]; the incoming ADDI x11 is dropped
        bus.ex_ready = 1'b0;
        send(32'h00100213, 64'h130);
        bus.flush    = 1'b1;
        bus.if_valid = 1'b1;
        bus.if_inst  = 32'h00100593;
        @(negedge clk);
        check("flush_if_ready", 64'(bus.if_ready), 64'd0);
        tick();
        bus.flush    = 1'b0;
        bus.if_valid = 1'b0;
        check("flush_ex_valid", 64'(bus.ex_valid), 64'd0);
        check("flush_busy", 64'(busy_obs), 64'd0);
        bus.ex_ready = 1'b1;

        // Reset during a RAW stall with backpressure
        bus.ex_ready = 1'b0;
        send(32'h00500093, 64'h140);
        bus.if_valid = 1'b1;
        bus.if_inst  = 32'h001081B3;
        bus.if_pc    = 64'h144;
        tick();
        rst = 1'b1;
        #1;
        check("rst_mid_ex_valid", 64'(bus.ex_valid), 64'd0);
        check("rst_mid_busy", 64'(busy_obs), 64'd0);
        tick();
        rst = 1'b0;
        bus.ex_ready = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 64'(bus.if_ready), 64'd1);
        tick();
        bus.if_valid = 1'b0;
        repeat (3) tick();
        check("queue_drain", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
